// File: rtl/dec8b10b_sync_ctrl.sv
// Comma-based word synchronisation and error monitoring around an external
// 8b/10b decoder. The block shares the running disparity register with the
// decoder. It acquires lock on K28.5 commas, and it tracks a leaky error
// level while locked. Only symbols received while locked reach the output.
//
// Handshake: sym_valid qualifies sym_in for exactly one cycle, and there is
// no backpressure. The FSM, the counters and rd advance only on sym_valid
// cycles. out_valid is a one-cycle strobe. out_data, out_k and out_err hold
// their values between strobes.
module dec8b10b_sync_ctrl #(
  parameter int COMMA_TARGET = 3,
  parameter int GOOD_RUN     = 4,
  parameter int ERR_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sym_valid,
  input  logic [9:0]  sym_in,
  output logic [9:0]  dec_datain,
  output logic        dec_dispin,
  input  logic [8:0]  dec_dataout,
  input  logic        dec_dispout,
  input  logic        dec_code_err,
  input  logic        dec_disp_err,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_k,
  output logic        out_err,
  output logic        sync_ok,
  output logic [2:0]  err_lvl,
  output logic [15:0] err_total,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_LOS  = 2'd0,
    ST_CDET = 2'd1,
    ST_SYNC = 2'd2
  } state_t;

  localparam int CDW = $clog2(COMMA_TARGET + 1);
  localparam int GW  = $clog2(GOOD_RUN + 1);
  localparam logic [CDW-1:0] CD_TGT   = CDW'(COMMA_TARGET);
  localparam logic [GW-1:0]  GOOD_TGT = GW'(GOOD_RUN);
  localparam logic [2:0]     LVL_MAX  = 3'(ERR_LIMIT);

  state_t         state_q;
  logic           rd_q;
  logic [CDW-1:0] cd_cnt_q, cd_cnt_d;
  logic [GW-1:0]  good_cnt_q, good_cnt_d;
  logic [2:0]     err_lvl_q, err_lvl_d;
  logic [15:0]    err_total_q;
  logic           out_valid_q, out_k_q, out_err_q, sync_ok_q;
  logic [7:0]     out_data_q;
  logic           invalid, comma;

  // A comma ignores disparity errors, so a comma with the wrong disparity
  // still counts toward acquisition.
  assign invalid    = dec_code_err | dec_disp_err;
  assign comma      = (dec_dataout == 9'h1BC) & ~dec_code_err;
  assign cd_cnt_d   = cd_cnt_q + CDW'(1);
  assign good_cnt_d = good_cnt_q + GW'(1);
  assign err_lvl_d  = err_lvl_q + 3'd1;

  assign dec_datain = sym_in;
  assign dec_dispin = rd_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_k      = out_k_q;
  assign out_err    = out_err_q;
  assign sync_ok    = sync_ok_q;
  assign err_lvl    = err_lvl_q;
  assign err_total  = err_total_q;
  assign dbg_state  = state_q;

  // Sync FSM, error counters, disparity tracking and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOS;
      rd_q        <= 1'b0;
      cd_cnt_q    <= '0;
      good_cnt_q  <= '0;
      err_lvl_q   <= 3'd0;
      err_total_q <= 16'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_k_q     <= 1'b0;
      out_err_q   <= 1'b0;
      sync_ok_q   <= 1'b0;
    end else begin
      out_valid_q <= sym_valid && (state_q == ST_SYNC);
      if (sym_valid) begin
        rd_q <= dec_dispout;
        case (state_q)
          ST_LOS: begin
            if (comma) begin
              if (CD_TGT == CDW'(1)) begin
                state_q    <= ST_SYNC;
                sync_ok_q  <= 1'b1;
                err_lvl_q  <= 3'd0;
                good_cnt_q <= '0;
                cd_cnt_q   <= '0;
              end else begin
                state_q  <= ST_CDET;
                cd_cnt_q <= CDW'(1);
              end
            end
          end
          ST_CDET: begin
            if (comma) begin
              if (cd_cnt_d == CD_TGT) begin
                state_q    <= ST_SYNC;
                sync_ok_q  <= 1'b1;
                err_lvl_q  <= 3'd0;
                good_cnt_q <= '0;
                cd_cnt_q   <= '0;
              end else begin
                cd_cnt_q <= cd_cnt_d;
              end
            end else if (invalid) begin
              state_q  <= ST_LOS;
              cd_cnt_q <= '0;
            end
          end
          ST_SYNC: begin
            out_data_q <= dec_dataout[7:0];
            out_k_q    <= dec_dataout[8];
            out_err_q  <= invalid;
            if (invalid) begin
              good_cnt_q <= '0;
              if (err_total_q != 16'hFFFF) err_total_q <= err_total_q + 16'd1;
              // err_lvl stays at the limit through LOS and CDET until relock.
              if (err_lvl_d >= LVL_MAX) begin
                err_lvl_q <= LVL_MAX;
                state_q   <= ST_LOS;
                sync_ok_q <= 1'b0;
              end else begin
                err_lvl_q <= err_lvl_d;
              end
            end else if (err_lvl_q != 3'd0) begin
              if (good_cnt_d == GOOD_TGT) begin
                err_lvl_q  <= err_lvl_q - 3'd1;
                good_cnt_q <= '0;
              end else begin
                good_cnt_q <= good_cnt_d;
              end
            end else begin
              good_cnt_q <= '0;
            end
          end
          default: begin
            state_q   <= ST_LOS;
            sync_ok_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dec8b10b_sync_ctrl.sv
// Bench for dec8b10b_sync_ctrl. It includes a small 8b/10b decoder model
// for the K28.5 and D21.5 code groups and a reference model of lock and
// error level. A queue of expected decoded symbols is compared at each
// output strobe.
module tb_dec8b10b_sync_ctrl;
  localparam int CT = 3;
  localparam int GR = 4;
  localparam int EL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sym_valid = 1'b0;
  logic [9:0]  sym_in = 10'd0;
  logic [9:0]  dec_datain;
  logic        dec_dispin;
  logic [8:0]  dec_dataout;
  logic        dec_dispout, dec_code_err, dec_disp_err;
  logic        out_valid, out_k, out_err, sync_ok;
  logic [7:0]  out_data;
  logic [2:0]  err_lvl;
  logic [15:0] err_total;
  logic [1:0]  dbg_state;

  dec8b10b_sync_ctrl #(.COMMA_TARGET(CT), .GOOD_RUN(GR), .ERR_LIMIT(EL)) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_in(sym_in),
    .dec_datain(dec_datain), .dec_dispin(dec_dispin), .dec_dataout(dec_dataout),
    .dec_dispout(dec_dispout), .dec_code_err(dec_code_err), .dec_disp_err(dec_disp_err),
    .out_valid(out_valid), .out_data(out_data), .out_k(out_k), .out_err(out_err),
    .sync_ok(sync_ok), .err_lvl(err_lvl), .err_total(err_total), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Decoder model: returns {code_err, disp_err, dispout, dataout[8:0]}.
  // 17C is K28.5 RD-, 283 is K28.5 RD+, 2AA is D21.5 (neutral).
  function automatic logic [11:0] dec_fn(input logic [9:0] s, input logic rd);
    logic [8:0] d;
    logic       dout, ce, de;
    d = 9'h000; dout = rd; ce = 1'b0; de = 1'b0;
    case (s)
      10'h17C: begin d = 9'h1BC; dout = 1'b1; de = rd;  end
      10'h283: begin d = 9'h1BC; dout = 1'b0; de = ~rd; end
      10'h2AA: begin d = 9'h0B5; dout = rd;             end
      default: ce = 1'b1;
    endcase
    return {ce, de, dout, d};
  endfunction

  assign {dec_code_err, dec_disp_err, dec_dispout, dec_dataout} = dec_fn(dec_datain, dec_dispin);

  // Scoreboard and reference model
  int          n_tests = 0;
  int          n_fail = 0;
  logic [9:0]  exp_q[$];   // {k, err, data}
  logic [9:0]  m_last;
  int          m_state, m_cd, m_good, m_lvl, m_tot;
  logic        m_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cd = 0; m_good = 0; m_lvl = 0; m_tot = 0;
    m_rd = 1'b0; m_last = 10'd0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [9:0] s, output logic pushed);
    logic [11:0] r;
    logic        inv, cm;
    r = dec_fn(s, m_rd);
    inv = r[11] | r[10];
    cm = (r[8:0] == 9'h1BC) && !r[11];
    pushed = 1'b0;
    if (m_state == 2) begin
      exp_q.push_back({r[8], inv, r[7:0]});
      pushed = 1'b1;
    end
    m_rd = r[9];
    case (m_state)
      0: if (cm) begin m_cd = 1; m_state = 1; end
      1: begin
        if (cm) begin
          m_cd++;
          if (m_cd == CT) begin m_state = 2; m_lvl = 0; m_good = 0; m_cd = 0; end
        end else if (inv) begin
          m_state = 0; m_cd = 0;
        end
      end
      default: begin
        if (inv) begin
          m_good = 0;
          if (m_tot < 65535) m_tot++;
          m_lvl++;
          if (m_lvl >= EL) begin m_lvl = EL; m_state = 0; end
        end else if (m_lvl > 0) begin
          m_good++;
          if (m_good == GR) begin m_lvl--; m_good = 0; end
        end else begin
          m_good = 0;
        end
      end
    endcase
  endtask

  task automatic check_regs();
    check("sync_ok", sync_ok, (m_state == 2) ? 1 : 0);
    check("err_lvl", err_lvl, m_lvl);
    check("err_total", err_total, m_tot);
    check("rd", dec_dispin, m_rd);
    check("state", dbg_state, m_state);
  endtask

  task automatic check_out(input logic pushed);
    logic [9:0] e;
    check("out_valid", out_valid, pushed);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e[7:0]);
        check("out_err", out_err, e[8]);
        check("out_k", out_k, e[9]);
        m_last = e;
      end
    end else begin
      if (pushed && exp_q.size() != 0) void'(exp_q.pop_back());
      check("out_hold", {out_k, out_err, out_data}, m_last);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic send(input logic [9:0] s);
    logic p;
    sym_in = s;
    sym_valid = 1'b1;
    model_step(s, p);
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    check_out(p);
    check_regs();
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_out(1'b0);
      check_regs();
    end
  endtask

  task automatic send_comma();
    send(m_rd ? 10'h283 : 10'h17C);
  endtask

  // Stimulus
  initial begin
    int pick;
    model_reset();
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sync_ok", sync_ok, 0);
    check_regs();
    rst_n = 1'b1;

    // Acquire from the three commas in the defined order.
    send(10'h17C);
    send(10'h283);
    check("acq_not_yet", sync_ok, 0);
    send(10'h17C);
    check("acq_sync", sync_ok, 1);

    // Data path
    send(10'h2AA);
    check("d21_5_data", out_data, 8'hB5);
    check("d21_5_rd", dec_dispin, 1);
    gap(2);

    // Loss: four invalid symbols
    for (int i = 0; i < 4; i++) begin
      send(10'h000);
      check("loss_lvl", err_lvl, i + 1);
      check("loss_err", out_err, 1);
    end
    check("loss_sync", sync_ok, 0);
    check("loss_total", err_total, 4);
    gap(1);

    // Reacquire, then recover: one error followed by four good symbols
    for (int i = 0; i < 3; i++) send_comma();
    check("reacq_lvl0", err_lvl, 0);
    send(10'h000);
    check("rec_lvl1", err_lvl, 1);
    for (int i = 0; i < 4; i++) begin
      send(10'h2AA);
      check("rec_lvl", err_lvl, (i == 3) ? 0 : 1);
      check("rec_sync", sync_ok, 1);
    end

    // Abort during comma detection
    for (int i = 0; i < 4; i++) send(10'h000);
    send_comma();
    send_comma();
    send(10'h000);
    check("abort_los", dbg_state, 0);
    send_comma();
    send_comma();
    check("abort_not_sync", sync_ok, 0);
    send_comma();
    check("abort_sync", sync_ok, 1);

    // Random traffic with gaps
    for (int i = 0; i < 300; i++) begin
      pick = $urandom_range(0, 99);
      if (pick < 40)      send_comma();
      else if (pick < 75) send(10'h2AA);
      else if (pick < 90) send(10'h000 | 10'($urandom_range(0, 3)));
      else                send(m_rd ? 10'h17C : 10'h283);
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
    end

    // Asynchronous reset while locked and a symbol is pending
    for (int i = 0; i < 3; i++) send_comma();
    send(10'h2AA);
    sym_in = 10'h2AA;
    sym_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_sync_ok", sync_ok, 0);
    check("arst_rd", dec_dispin, 0);
    check("arst_total", err_total, 0);
    model_reset();
    sym_valid = 1'b0;
    @(posedge clk);
    #1;
    check_out(1'b0);
    check_regs();
    rst_n = 1'b1;
    gap(1);
    for (int i = 0; i < 3; i++) send_comma();
    check("post_rst_sync", sync_ok, 1);
    send(10'h2AA);
    gap(1);

    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
